// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave
//
// SPI mode 0 (CPOL=0, CPHA=0) slave, 8-bit frames, MSB first, oversampled by
// the system clock raw_clk. The SPI pins are asynchronous to raw_clk and are
// brought in through two-flop synchronizers; sclk and cs_n edges are found by
// comparing the second synchronizer stage with a third registered copy.
// A pin transition first sampled at raw_clk edge N takes effect at edge N+2.
//
// The master must hold each sclk phase, and cs_n setup/hold around sclk, for
// at least 4 raw_clk periods so that every edge is seen and mosi is stable
// when a rising sclk edge is acted on.
//
// Ports
//   raw_clk   in   system clock, rising edge active
//   reset     in   synchronous, active-high reset
//   sclk      in   SPI clock from the master (asynchronous)
//   cs_n      in   SPI chip select, active low (asynchronous)
//   mosi      in   serial data from the master (asynchronous)
//   miso      out  serial data to the master; 0 while deselected
//   tx_data   in   byte written into the transmit buffer
//   tx_load   in   one-cycle strobe: write tx_data into the transmit buffer
//   tx_ready  out  transmit buffer empty; a tx_load will be accepted
//   rx_data   out  last received byte
//   rx_valid  out  rx_data holds a byte the CPU has not yet acknowledged
//   rx_ack    in   one-cycle strobe: CPU has read rx_data
//   overrun   out  sticky: a completed byte was dropped (cleared by reset)
//   busy      out  high while the synchronized chip select is low
// -----------------------------------------------------------------------------
module spi_slave #(
    parameter logic [7:0] IDLE_BYTE = 8'hFF
) (
    input  logic       raw_clk,
    input  logic       reset,
    input  logic       sclk,
    input  logic       cs_n,
    input  logic       mosi,
    output logic       miso,
    input  logic [7:0] tx_data,
    input  logic       tx_load,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ack,
    output logic       overrun,
    output logic       busy
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    // Synchronizer stages: _p0 is the first flop, _p1 the second, _p2 the
    // extra copy used only for edge detection.
    logic sclk_p0, sclk_p1, sclk_p2;
    logic cs_p0, cs_p1, cs_p2;
    logic mosi_p0, mosi_p1;

    logic [0:0] state;
    logic [2:0] bit_cnt;
    logic [7:0] tx_sr;
    logic [6:0] rx_sr;
    logic [7:0] tx_buf;

    logic       sclk_rise, sclk_fall;
    logic       cs_fall, cs_rise;
    logic       shift_edge_ok;
    logic       byte_done;
    logic       tx_take;
    logic       tx_consume;
    logic [7:0] tx_next;
    logic [7:0] rx_byte;

    // ---- stage p0/p1/p2: pin synchronizers ----
    // Reset loads the idle pin levels so that releasing reset never creates
    // a phantom edge on an idle bus.
    always_ff @(posedge raw_clk) begin
        if (reset) begin
            sclk_p0 <= 1'b0;
            sclk_p1 <= 1'b0;
            sclk_p2 <= 1'b0;
            cs_p0   <= 1'b1;
            cs_p1   <= 1'b1;
            cs_p2   <= 1'b1;
            mosi_p0 <= 1'b0;
            mosi_p1 <= 1'b0;
        end else begin
            sclk_p0 <= sclk;
            sclk_p1 <= sclk_p0;
            sclk_p2 <= sclk_p1;
            cs_p0   <= cs_n;
            cs_p1   <= cs_p0;
            cs_p2   <= cs_p1;
            mosi_p0 <= mosi;
            mosi_p1 <= mosi_p0;
        end
    end

    // ---- edge detection and transfer decode ----
    always_comb begin
        sclk_rise = sclk_p1 & ~sclk_p2;
        sclk_fall = ~sclk_p1 & sclk_p2;
        cs_fall   = ~cs_p1 & cs_p2;
        cs_rise   = cs_p1 & ~cs_p2;

        // A deselect wins over any sclk edge seen in the same cycle.
        shift_edge_ok = (state == SHIFT) && !cs_rise;

        byte_done = shift_edge_ok && sclk_rise && (bit_cnt == 3'd7);

        // The transmit shifter is (re)loaded at frame start and on the falling
        // edge that follows a completed byte (bit_cnt has just wrapped to 0).
        tx_take = ((state == IDLE) && cs_fall) ||
                  (shift_edge_ok && sclk_fall && (bit_cnt == 3'd0));

        // Only a full buffer is consumed; an empty one supplies IDLE_BYTE.
        tx_consume = tx_take && !tx_ready;
        tx_next    = tx_ready ? IDLE_BYTE : tx_buf;

        rx_byte = {rx_sr, mosi_p1};
    end

    // ---- frame state, bit counter and shift registers ----
    always_ff @(posedge raw_clk) begin
        if (reset) begin
            state   <= IDLE;
            bit_cnt <= 3'd0;
            tx_sr   <= 8'h00;
            rx_sr   <= 7'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state   <= SHIFT;
                        bit_cnt <= 3'd0;
                        tx_sr   <= tx_next;
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        // Deselect mid-byte: drop whatever was partially shifted.
                        state   <= IDLE;
                        bit_cnt <= 3'd0;
                        rx_sr   <= 7'h00;
                        tx_sr   <= 8'h00;
                    end else begin
                        if (sclk_rise) begin
                            rx_sr   <= rx_byte[6:0];
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                        if (sclk_fall) begin
                            if (bit_cnt != 3'd0) begin
                                tx_sr <= {tx_sr[6:0], 1'b0};
                            end else begin
                                tx_sr <= tx_next;
                            end
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // ---- transmit buffer ----
    // Consumption and tx_load cannot both act: consumption needs a full
    // buffer, and a full buffer refuses tx_load.
    always_ff @(posedge raw_clk) begin
        if (reset) begin
            tx_buf   <= 8'h00;
            tx_ready <= 1'b1;
        end else if (tx_consume) begin
            tx_ready <= 1'b1;
        end else if (tx_load && tx_ready) begin
            tx_buf   <= tx_data;
            tx_ready <= 1'b0;
        end
    end

    // ---- receive holding register and status ----
    // An ack in the completing cycle frees the slot just in time, so the new
    // byte is stored and rx_valid simply stays high.
    always_ff @(posedge raw_clk) begin
        if (reset) begin
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end else if (byte_done) begin
            if (rx_valid && !rx_ack) begin
                overrun <= 1'b1;
            end else begin
                rx_data  <= rx_byte;
                rx_valid <= 1'b1;
            end
        end else if (rx_ack) begin
            rx_valid <= 1'b0;
        end
    end

    assign miso = (state == SHIFT) ? tx_sr[7] : 1'b0;
    assign busy = (state == SHIFT);

endmodule

// File: tb/tb_spi_slave.sv
// -----------------------------------------------------------------------------
// tb_spi_slave
//
// Drives spi_slave as a mode-0 SPI master plus a CPU side, and checks it
// against a byte-level reference model: a one-entry transmit mailbox that is
// drained at each frame start and after each completed byte, and a one-entry
// receive mailbox with ack / overrun rules.
// -----------------------------------------------------------------------------
module tb_spi_slave;

    localparam int         HALF   = 6;
    localparam logic [7:0] IDLE_B = 8'hFF;

    logic       raw_clk = 1'b0;
    logic       reset   = 1'b1;
    logic       sclk    = 1'b0;
    logic       cs_n    = 1'b1;
    logic       mosi    = 1'b0;
    logic       miso;
    logic [7:0] tx_data = 8'h00;
    logic       tx_load = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack  = 1'b0;
    logic       overrun;
    logic       busy;

    spi_slave #(.IDLE_BYTE(IDLE_B)) dut (
        .raw_clk  (raw_clk),
        .reset    (reset),
        .sclk     (sclk),
        .cs_n     (cs_n),
        .mosi     (mosi),
        .miso     (miso),
        .tx_data  (tx_data),
        .tx_load  (tx_load),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ack   (rx_ack),
        .overrun  (overrun),
        .busy     (busy)
    );

    always #5 raw_clk = ~raw_clk;

    int total  = 0;
    int passed = 0;

    // Reference model state
    bit         m_pend  = 1'b0;
    logic [7:0] m_buf   = 8'h00;
    logic [7:0] m_cur   = 8'h00;
    bit         m_valid = 1'b0;
    logic [7:0] m_data  = 8'h00;
    bit         m_ovr   = 1'b0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic m_take(output logic [7:0] b);
        if (m_pend) begin
            b      = m_buf;
            m_pend = 1'b0;
        end else begin
            b = IDLE_B;
        end
    endtask

    task automatic m_reset();
        m_pend  = 1'b0;
        m_buf   = 8'h00;
        m_valid = 1'b0;
        m_data  = 8'h00;
        m_ovr   = 1'b0;
    endtask

    task automatic cpu_load(input logic [7:0] d);
        @(negedge raw_clk);
        tx_data = d;
        tx_load = 1'b1;
        @(negedge raw_clk);
        tx_load = 1'b0;
        if (!m_pend) begin
            m_pend = 1'b1;
            m_buf  = d;
        end
    endtask

    task automatic cpu_ack();
        @(negedge raw_clk);
        rx_ack = 1'b1;
        @(negedge raw_clk);
        rx_ack = 1'b0;
        m_valid = 1'b0;
    endtask

    // Master clocks n bits of mo (MSB first). With ack_done set, rx_ack is
    // raised exactly in the cycle the slave acts on the 8th rising edge.
    task automatic spi_bits(input logic [7:0] mo, input int n, input bit ack_done,
                            output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 7; i > 7 - n; i--) begin
            mosi = mo[i];
            repeat (HALF) @(negedge raw_clk);
            mi[i] = miso;
            sclk = 1'b1;
            if (i == 0 && ack_done) begin
                @(negedge raw_clk);
                @(negedge raw_clk);
                rx_ack = 1'b1;
                @(negedge raw_clk);
                rx_ack = 1'b0;
                repeat (HALF - 3) @(negedge raw_clk);
            end else begin
                repeat (HALF) @(negedge raw_clk);
            end
            sclk = 1'b0;
        end
    endtask

    task automatic frame_start();
        @(negedge raw_clk);
        cs_n = 1'b0;
        m_take(m_cur);
        repeat (HALF) @(negedge raw_clk);
    endtask

    task automatic frame_end();
        repeat (HALF) @(negedge raw_clk);
        cs_n = 1'b1;
        repeat (HALF) @(negedge raw_clk);
    endtask

    task automatic xfer_byte(input logic [7:0] mo, input bit ack_done, input string tag);
        logic [7:0] mi;
        spi_bits(mo, 8, ack_done, mi);
        check({tag, " miso"}, mi, m_cur);
        if (m_valid && !ack_done) begin
            m_ovr = 1'b1;
        end else begin
            m_data  = mo;
            m_valid = 1'b1;
        end
        if (ack_done) m_valid = 1'b1;
        m_take(m_cur);
        check({tag, " rx_data"}, rx_data, m_data);
        check({tag, " rx_valid"}, {7'd0, rx_valid}, {7'd0, m_valid});
        check({tag, " overrun"}, {7'd0, overrun}, {7'd0, m_ovr});
        check({tag, " busy"}, {7'd0, busy}, 8'd1);
    endtask

    task automatic check_idle(input string tag);
        check({tag, " busy"}, {7'd0, busy}, 8'd0);
        check({tag, " miso"}, {7'd0, miso}, 8'd0);
        check({tag, " tx_ready"}, {7'd0, tx_ready}, {7'd0, !m_pend});
        check({tag, " rx_valid"}, {7'd0, rx_valid}, {7'd0, m_valid});
        check({tag, " overrun"}, {7'd0, overrun}, {7'd0, m_ovr});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " miso"}, {7'd0, miso}, 8'd0);
        check({tag, " busy"}, {7'd0, busy}, 8'd0);
        check({tag, " tx_ready"}, {7'd0, tx_ready}, 8'd1);
        check({tag, " rx_data"}, rx_data, 8'h00);
        check({tag, " rx_valid"}, {7'd0, rx_valid}, 8'd0);
        check({tag, " overrun"}, {7'd0, overrun}, 8'd0);
    endtask

    initial begin
        logic [7:0] junk;
        int         nb;

        // Reset state
        repeat (4) @(negedge raw_clk);
        check_reset_outputs("rst_hold");
        reset = 1'b0;
        repeat (4) @(negedge raw_clk);
        check_reset_outputs("rst_rel");
        m_reset();

        // Loaded byte goes out while a byte comes in
        cpu_load(8'hA5);
        check("load tx_ready", {7'd0, tx_ready}, 8'd0);
        frame_start();
        check("t35 busy", {7'd0, busy}, 8'd1);
        check("t35 tx_ready", {7'd0, tx_ready}, 8'd1);
        xfer_byte(8'h3C, 1'b0, "t35");
        frame_end();
        check_idle("t35 end");
        cpu_ack();

        // Empty buffer sends the idle byte, ack between bytes
        frame_start();
        xfer_byte(8'h01, 1'b0, "t36a");
        cpu_ack();
        check("t36 ack rx_valid", {7'd0, rx_valid}, 8'd0);
        xfer_byte(8'h02, 1'b0, "t36b");
        frame_end();
        check_idle("t36 end");
        cpu_ack();

        // Ack in the completing cycle while a byte is still unread
        frame_start();
        xfer_byte(8'h33, 1'b0, "t39a");
        xfer_byte(8'h55, 1'b1, "t39b");
        frame_end();
        check_idle("t39 end");
        cpu_ack();

        // Deselect after 5 rising edges, then a clean byte
        frame_start();
        spi_bits(8'h5A, 5, 1'b0, junk);
        frame_end();
        check_idle("t38 abort");
        frame_start();
        xfer_byte(8'h7E, 1'b0, "t38");
        frame_end();
        check_idle("t38 end");
        cpu_ack();

        // Two bytes without ack: second is dropped
        frame_start();
        xfer_byte(8'h11, 1'b0, "t37a");
        xfer_byte(8'h22, 1'b0, "t37b");
        frame_end();
        check_idle("t37 end");
        cpu_ack();

        // Randomized frames
        for (int f = 0; f < 30; f++) begin
            if ($urandom_range(1, 0) == 1) cpu_load(8'($urandom));
            frame_start();
            nb = int'($urandom_range(3, 1));
            for (int b = 0; b < nb; b++) begin
                if (b > 0) begin
                    if ($urandom_range(2, 0) == 0) cpu_ack();
                    if ($urandom_range(2, 0) == 0) begin
                        repeat (4) @(negedge raw_clk);
                        cpu_load(8'($urandom));
                    end
                end
                xfer_byte(8'($urandom), ($urandom_range(3, 0) == 0), "rnd");
            end
            frame_end();
            check_idle("rnd end");
            if ($urandom_range(1, 0) == 1) cpu_ack();
        end

        // Reset part-way through a byte, then a refused load
        cpu_load(8'hC3);
        frame_start();
        spi_bits(8'hB7, 3, 1'b0, junk);
        @(negedge raw_clk);
        reset = 1'b1;
        cs_n  = 1'b1;
        repeat (3) @(negedge raw_clk);
        reset = 1'b0;
        m_reset();
        repeat (4) @(negedge raw_clk);
        check_reset_outputs("t40 rst");
        cpu_load(8'h81);
        cpu_load(8'h42);
        check("t40 tx_ready", {7'd0, tx_ready}, 8'd0);
        frame_start();
        xfer_byte(8'h99, 1'b0, "t40");
        frame_end();
        check_idle("t40 end");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter IDLE_BYTE, default 8'hFF: byte shifted out when no transmit data is pending.
REQ-002 raw_clk  input  1  system clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on raw_clk.
REQ-004 sclk  input  1  SPI clock from external master, asynchronous to raw_clk.
REQ-005 cs_n  input  1  SPI chip select, active low, asynchronous.
REQ-006 mosi  input  1  serial data from master, asynchronous.
REQ-007 miso  output  1  serial data to master.
REQ-008 tx_data  input  8  byte written to the transmit buffer.
REQ-009 tx_load  input  1  one-cycle strobe: write tx_data into the transmit buffer.
REQ-010 tx_ready  output  1  transmit buffer empty; tx_load accepted.
REQ-011 rx_data  output  8  last received byte.
REQ-012 rx_valid  output  1  rx_data holds an unread byte.
REQ-013 rx_ack  input  1  one-cycle strobe: CPU has read rx_data.
REQ-014 overrun  output  1  sticky flag: a received byte was dropped.
REQ-015 busy  output  1  high while cs_n (synchronized) is low.

Function
REQ-016 sclk, cs_n and mosi SHALL each pass through a 2-flop synchronizer; sclk edges SHALL be detected by comparing stage-2 output with a third registered copy.
REQ-017 Action latency: a pin transition first sampled at raw_clk edge N SHALL take effect at edge N+2.
REQ-018 Timing contract: master sclk high and low phases each ≥ 4 raw_clk periods; cs_n setup/hold to sclk ≥ 4 raw_clk periods.
REQ-019 Protocol: SPI mode 0 (CPOL=0, CPHA=0), 8-bit, MSB first.
REQ-020 States: IDLE (cs_n high) and SHIFT (cs_n low); 3-bit bit counter bit_cnt.
REQ-021 IDLE -> SHIFT on detected cs_n fall: bit_cnt=0; tx shift register loaded from transmit buffer if full (buffer marked empty), else IDLE_BYTE.
REQ-022 SHIFT -> IDLE on detected cs_n rise: bit_cnt=0, partial rx byte discarded, no rx_valid change.
REQ-023 miso SHALL equal tx shift register bit 7 in SHIFT and 0 in IDLE.
REQ-024 On detected sclk rise in SHIFT: rx shift register shifts left, synchronized mosi into bit 0; bit_cnt increments modulo 8.
REQ-025 On the rising edge where bit_cnt wraps 7->0, the completed byte SHALL be written to rx_data and rx_valid set, unless REQ-027 applies.
REQ-026 rx_ack SHALL clear rx_valid; rx_ack with rx_valid low has no effect.
REQ-027 Byte completes while rx_valid=1 and rx_ack=0 in that cycle: byte discarded, rx_data unchanged, overrun set.
REQ-028 Byte completes in the same cycle as rx_ack: new byte stored, rx_valid stays 1, overrun unchanged.
REQ-029 On detected sclk fall in SHIFT: if bit_cnt≠0, tx shift register shifts left (0 in); if bit_cnt=0 (byte just completed), reload per REQ-021 rule.
REQ-030 tx_load with tx_ready=1 SHALL store tx_data and clear tx_ready next cycle; tx_load with tx_ready=0 SHALL be ignored.
REQ-031 tx_load in the same cycle as buffer consumption: buffer consumed first, tx_load ignored (tx_ready was 0).
REQ-032 overrun SHALL clear only on reset.

Reset
REQ-033 reset SHALL force: IDLE, bit_cnt=0, miso=0, tx_ready=1, rx_data=0, rx_valid=0, overrun=0, busy=0, shift registers 0.
REQ-034 reset SHALL load synchronizer flops with sclk=0, cs_n=1, mosi=0 so no false edge follows reset release; reset mid-transfer aborts the byte.

Verification
REQ-035 tx_load 8'hA5, cs_n low, master clocks 8'h3C -> miso bits 1,0,1,0,0,1,0,1; rx_data=8'h3C, rx_valid=1, tx_ready=1.
REQ-036 No tx_load, two-byte transfer 8'h01,8'h02 with rx_ack between -> miso 8'hFF twice; rx_data 8'h01 then 8'h02, overrun=0.
REQ-037 Two bytes 8'h11,8'h22 without rx_ack -> rx_data=8'h11, rx_valid=1, overrun=1.
REQ-038 cs_n raised after 5 sclk rises -> state IDLE, miso=0, rx_valid=0; next full byte 8'h7E received correctly.
REQ-039 rx_ack asserted in the completing cycle of byte 8'h55 -> rx_data=8'h55, rx_valid=1, overrun=0.
REQ-040 reset pulsed after 3 bits -> all outputs per REQ-033; tx_load while tx_ready=0 leaves buffer unchanged.
